sprite_blitter: RTL and testbench
=================================

// Module: sprite_blitter
// PURPOSE
// - Writer side of the sprite path: copies one sprite from its palette-index ROM into the
//   framebuffer RAM that the display side reads. Writes land at a latched (pos_x,pos_y).
// - Skips transparent pixels, clips against framebuffer edges, and supports horizontal flip
//   for the left/right-facing knight. Sits between game logic (start/done) and the framebuffer write port.
// PARAMETERS
// - SPR_W     50   sprite width in pixels
// - SPR_H     64   sprite height in pixels
// - FB_W      320  framebuffer width in pixels
// - FB_H      240  framebuffer height in pixels
// - IDX_BITS  3    palette index width (ROM data / framebuffer data)
// - TRANSP    0    palette index treated as transparent (never written)
// - ROM_AW    12   sprite ROM address width (>= clog2(SPR_W*SPR_H))
// - FB_AW     17   framebuffer address width (>= clog2(FB_W*FB_H))
// PORTS
// - Clk          in   1         system clock; all logic on posedge
// - Reset        in   1         synchronous, active-high reset
// - start        in   1         request a blit; sampled only when busy=0
// - pos_x        in   11        signed destination X of sprite column 0 (two's complement)
// - pos_y        in   11        signed destination Y of sprite row 0
// - flip_x       in   1         1 = mirror sprite horizontally
// - busy         out  1         high from cycle after accepted start until done
// - done         out  1         one-cycle pulse when the final write has been issued
// - rom_address  out  ROM_AW    sprite ROM read address (sy*SPR_W + sx)
// - rom_q        in   IDX_BITS  ROM data; valid the cycle after rom_address (sync ROM)
// - fb_we        out  1         framebuffer write enable
// - fb_addr      out  FB_AW     framebuffer write address (dy*FB_W + dx)
// - fb_data      out  IDX_BITS  palette index written
// BEHAVIOUR
// - Reset: state IDLE; busy=0, done=0, fb_we=0, rom_address=0, fb_addr=0, fb_data=0; pipeline valids cleared.
// - States: IDLE -> READ -> DRAIN -> IDLE.
//   IDLE: start=1 latches pos_x, pos_y, flip_x, clears sx=sy=0, goes to READ. Other inputs ignored.
//   READ: issues one ROM address per cycle, raster order (sx 0..SPR_W-1, then sy+1).
//         After address (SPR_W-1, SPR_H-1) -> DRAIN.
//   DRAIN: waits 2 cycles for the pipeline to empty. On exit, done=1 for one cycle and busy=0
//          in that same cycle. The state returns to IDLE.
// - Timing: start sampled in cycle 0; first address in cycle 1; last address in cycle N=SPR_W*SPR_H.
//   Address issued in cycle k gives rom_q in k+1 and a registered fb_we/fb_addr/fb_data in cycle k+2.
//   Last possible write is in cycle N+2; done is in cycle N+3. Throughput is 1 pixel/cycle.
//   Total time is fixed and independent of clipping or transparency.
// - Destination: dx = pos_x + (flip_x ? SPR_W-1-sx : sx); dy = pos_y + sy.
//   Compute in signed 12 bits, no wrap. (sx,sy,dx,dy) travel with a 2-stage valid pipeline.
// - Write condition: fb_we=1 only when valid && rom_q!=TRANSP && 0<=dx<FB_W && 0<=dy<FB_H.
//   Otherwise fb_we=0 and fb_addr/fb_data hold their previous values.
// - start while busy=1 is ignored, with no queuing.
//   start in the done cycle (busy=0) is accepted, so back-to-back blits have no gap beyond DRAIN.
// - Reset mid-blit: next cycle fb_we=0, busy=0, no done pulse, and in-flight pixels are discarded.
// - rom_address holds its last value while in IDLE and DRAIN.
// TESTING
// - Opaque sprite (all ROM=1), pos=(0,0), no flip -> 3200 writes; first is fb_addr=0 in cycle 3,
//   last is fb_addr=63*320+49=20209 in cycle 3202; done in cycle 3203.
// - ROM word 0 = 0 (transparent), rest = 5 -> no write to fb_addr 0; 3199 writes; done cycle unchanged.
// - flip_x=1, pos=(10,0), ROM(sx=0,sy=0)=3 -> that pixel written at fb_addr 59 with data 3.
// - pos=(-20,230) -> only dx 0..29 and dy 230..239 written (300 writes), with no address wrap.
//   done is still in cycle 3203.
// - start pulsed at cycle 100 during a blit -> ignored. start in the done cycle -> second blit
//   accepted; busy=1 in the next cycle.
// - Reset asserted at cycle 500 -> cycle 501: fb_we=0, busy=0; no done; a new start then behaves like the first blit.

Source files
------------

// File: rtl/sprite_blitter.sv
// Sprite blitter: streams one sprite out of its palette-index ROM into the
// framebuffer write port at a latched destination, dropping transparent
// pixels and pixels that fall outside the framebuffer. Supports horizontal
// mirroring. Fixed-length run: N address cycles plus a 2-cycle drain.
module sprite_blitter #(
  parameter int SPR_W    = 50,
  parameter int SPR_H    = 64,
  parameter int FB_W     = 320,
  parameter int FB_H     = 240,
  parameter int IDX_BITS = 3,
  parameter int TRANSP   = 0,
  parameter int ROM_AW   = 12,
  parameter int FB_AW    = 17
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                start,
  input  logic [10:0]         pos_x,
  input  logic [10:0]         pos_y,
  input  logic                flip_x,
  output logic                busy,
  output logic                done,
  output logic [ROM_AW-1:0]   rom_address,
  input  logic [IDX_BITS-1:0] rom_q,
  output logic                fb_we,
  output logic [FB_AW-1:0]    fb_addr,
  output logic [IDX_BITS-1:0] fb_data
);

  localparam int SX_W = (SPR_W > 1) ? $clog2(SPR_W) : 1;
  localparam int SY_W = (SPR_H > 1) ? $clog2(SPR_H) : 1;
  localparam logic [SX_W-1:0]     SX_LAST    = SX_W'(SPR_W - 1);
  localparam logic [SY_W-1:0]     SY_LAST    = SY_W'(SPR_H - 1);
  localparam logic signed [11:0]  FB_W_S     = 12'(FB_W);
  localparam logic signed [11:0]  FB_H_S     = 12'(FB_H);
  localparam logic [IDX_BITS-1:0] TRANSP_IDX = IDX_BITS'(TRANSP);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t              state_reg, state_next;
  logic [SX_W-1:0]     sx_reg, sx_next;
  logic [SY_W-1:0]     sy_reg, sy_next;
  logic [ROM_AW-1:0]   rom_addr_reg, rom_addr_next;
  logic                drain_reg, drain_next;
  logic                done_reg, done_next;
  logic                accept;

  logic signed [11:0]  pos_x_reg, pos_y_reg;
  logic                flip_reg;

  // Destination of the pixel whose ROM address is issued this cycle
  logic signed [11:0]  off_x, dx0, dy0;

  // Stage aligned with rom_q (one cycle behind the address)
  logic                v1_reg;
  logic signed [11:0]  dx1_reg, dy1_reg;

  logic                wr_ok;
  logic [FB_AW-1:0]    dst_addr;

  logic                fb_we_reg;
  logic [FB_AW-1:0]    fb_addr_reg;
  logic [IDX_BITS-1:0] fb_data_reg;

  // Next-state logic: raster scan counters, linear ROM address, drain timer
  always_comb begin
    state_next    = state_reg;
    sx_next       = sx_reg;
    sy_next       = sy_reg;
    rom_addr_next = rom_addr_reg;
    drain_next    = drain_reg;
    done_next     = 1'b0;
    accept        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          accept        = 1'b1;
          sx_next       = '0;
          sy_next       = '0;
          rom_addr_next = '0;
          state_next    = READ;
        end
      end
      READ: begin
        if (sx_reg == SX_LAST) begin
          if (sy_reg == SY_LAST) begin
            // Last address stays on the bus through the drain
            state_next = DRAIN;
            drain_next = 1'b0;
          end else begin
            sx_next       = '0;
            sy_next       = sy_reg + SY_W'(1);
            rom_addr_next = rom_addr_reg + ROM_AW'(1);
          end
        end else begin
          sx_next       = sx_reg + SX_W'(1);
          rom_addr_next = rom_addr_reg + ROM_AW'(1);
        end
      end
      DRAIN: begin
        if (drain_reg) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end else begin
          drain_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Destination arithmetic in signed 12 bits so off-screen values never wrap
  always_comb begin
    off_x = flip_reg ? (12'(SPR_W - 1) - 12'(sx_reg)) : 12'(sx_reg);
    dx0   = pos_x_reg + off_x;
    dy0   = pos_y_reg + $signed(12'(sy_reg));
  end

  // Control registers, latched blit parameters and the address-side pipeline stage
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg    <= IDLE;
      sx_reg       <= '0;
      sy_reg       <= '0;
      rom_addr_reg <= '0;
      drain_reg    <= 1'b0;
      done_reg     <= 1'b0;
      pos_x_reg    <= '0;
      pos_y_reg    <= '0;
      flip_reg     <= 1'b0;
      v1_reg       <= 1'b0;
      dx1_reg      <= '0;
      dy1_reg      <= '0;
    end else begin
      state_reg    <= state_next;
      sx_reg       <= sx_next;
      sy_reg       <= sy_next;
      rom_addr_reg <= rom_addr_next;
      drain_reg    <= drain_next;
      done_reg     <= done_next;
      if (accept) begin
        pos_x_reg <= {pos_x[10], pos_x};
        pos_y_reg <= {pos_y[10], pos_y};
        flip_reg  <= flip_x;
      end
      v1_reg  <= (state_reg == READ);
      dx1_reg <= dx0;
      dy1_reg <= dy0;
    end
  end

  // Write qualification: valid, opaque, and inside the framebuffer
  always_comb begin
    wr_ok = v1_reg && (rom_q != TRANSP_IDX) &&
            !dx1_reg[11] && (dx1_reg < FB_W_S) &&
            !dy1_reg[11] && (dy1_reg < FB_H_S);
    dst_addr = FB_AW'($unsigned(dy1_reg)) * FB_AW'(FB_W) + FB_AW'($unsigned(dx1_reg));
  end

  // Registered framebuffer write port; address/data hold when not writing
  always_ff @(posedge Clk) begin
    if (Reset) begin
      fb_we_reg   <= 1'b0;
      fb_addr_reg <= '0;
      fb_data_reg <= '0;
    end else begin
      fb_we_reg <= wr_ok;
      if (wr_ok) begin
        fb_addr_reg <= dst_addr;
        fb_data_reg <= rom_q;
      end
    end
  end

  assign busy        = (state_reg != IDLE);
  assign done        = done_reg;
  assign rom_address = rom_addr_reg;
  assign fb_we       = fb_we_reg;
  assign fb_addr     = fb_addr_reg;
  assign fb_data     = fb_data_reg;

endmodule

// File: tb/tb_sprite_blitter.sv
// Self-checking bench for sprite_blitter: a behavioural ROM, a per-cycle
// expected-write table computed from the sprite/destination arithmetic, and
// one summary line per blit.
module tb_sprite_blitter;

  localparam int SPR_W = 50;
  localparam int SPR_H = 64;
  localparam int N     = SPR_W * SPR_H;
  localparam int FB_W  = 320;
  localparam int FB_H  = 240;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        start = 1'b0;
  logic [10:0] pos_x = '0;
  logic [10:0] pos_y = '0;
  logic        flip_x = 1'b0;
  logic        busy, done;
  logic [11:0] rom_address;
  logic [2:0]  rom_q = '0;
  logic        fb_we;
  logic [16:0] fb_addr;
  logic [2:0]  fb_data;

  sprite_blitter dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .start       (start),
    .pos_x       (pos_x),
    .pos_y       (pos_y),
    .flip_x      (flip_x),
    .busy        (busy),
    .done        (done),
    .rom_address (rom_address),
    .rom_q       (rom_q),
    .fb_we       (fb_we),
    .fb_addr     (fb_addr),
    .fb_data     (fb_data)
  );

  always #5 Clk = ~Clk;

  // Synchronous sprite ROM
  logic [2:0] rom_mem [0:N-1];
  always @(posedge Clk) begin
    if (int'(rom_address) < N) rom_q <= rom_mem[rom_address];
    else                       rom_q <= 3'd0;
  end

  int vec_cnt  = 0;
  int miss_cnt = 0;
  int cur_k    = 0;

  // Expected write per cycle index relative to the start-sample cycle
  bit          exp_we   [0:N+5];
  logic [16:0] exp_addr [0:N+5];
  logic [2:0]  exp_data [0:N+5];
  int          exp_writes;
  logic [16:0] hold_addr = '0;
  logic [2:0]  hold_data = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miss_cnt++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cur_k, got, exp);
    end
  endtask

  // Pixel (sx,sy) is addressed in cycle 1+sy*W+sx and written two cycles later
  task automatic build_model(input int px, input int py, input bit fl);
    for (int c = 0; c <= N + 5; c++) exp_we[c] = 1'b0;
    exp_writes = 0;
    for (int sy = 0; sy < SPR_H; sy++) begin
      for (int sx = 0; sx < SPR_W; sx++) begin
        int p, dx, dy;
        p  = sy * SPR_W + sx;
        dx = px + (fl ? (SPR_W - 1 - sx) : sx);
        dy = py + sy;
        if (rom_mem[p] != 3'd0 && dx >= 0 && dx < FB_W && dy >= 0 && dy < FB_H) begin
          exp_we[p + 3]   = 1'b1;
          exp_addr[p + 3] = 17'(dy * FB_W + dx);
          exp_data[p + 3] = rom_mem[p];
          exp_writes++;
        end
      end
    end
  endtask

  task automatic fill_rom(input int lo, input int hi);
    for (int i = 0; i < N; i++) rom_mem[i] = 3'($urandom_range(hi, lo));
  endtask

  // One blit: optionally issue start, then check every cycle through done.
  task automatic blit(input int px, input int py, input bit fl, input bit issued,
                      input int poke_cyc, input int rst_cyc,
                      input bit chain, input int cpx, input int cpy, input bit cfl,
                      input int want_writes);
    int got_writes;
    got_writes = 0;
    build_model(px, py, fl);
    if (!issued) begin
      @(posedge Clk); #1;
      start = 1'b1; pos_x = 11'(px); pos_y = 11'(py); flip_x = fl;
    end
    @(posedge Clk); #1;
    // Scramble the parameter inputs: they must have been latched
    start = 1'b0; pos_x = 11'($urandom); pos_y = 11'($urandom); flip_x = 1'($urandom);
    for (int k = 1; k <= N + 3; k++) begin
      @(negedge Clk);
      cur_k = k;
      check("busy", 32'(busy), 32'(k <= N + 2));
      check("done", 32'(done), 32'(k == N + 3));
      if (k <= N) check("rom_addr", 32'(rom_address), 32'(k - 1));
      else        check("rom_hold", 32'(rom_address), 32'(N - 1));
      check("fb_we", 32'(fb_we), 32'(exp_we[k]));
      if (exp_we[k]) begin
        hold_addr = exp_addr[k];
        hold_data = exp_data[k];
      end
      check("fb_addr", 32'(fb_addr), 32'(hold_addr));
      check("fb_data", 32'(fb_data), 32'(hold_data));
      if (fb_we) got_writes++;
      if (k == poke_cyc) begin
        start = 1'b1; pos_x = 11'($urandom); pos_y = 11'($urandom);
      end
      if (k == poke_cyc + 1) start = 1'b0;
      if (k == rst_cyc) begin
        Reset = 1'b1;
        @(negedge Clk);
        cur_k = k + 1;
        Reset = 1'b0;
        check("rst_we", 32'(fb_we), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_addr", 32'(fb_addr), 32'd0);
        check("rst_data", 32'(fb_data), 32'd0);
        check("rst_rom", 32'(rom_address), 32'd0);
        hold_addr = '0;
        hold_data = '0;
        for (int j = 0; j < 12; j++) begin
          @(negedge Clk);
          cur_k = k + 2 + j;
          check("post_rst_we", 32'(fb_we), 32'd0);
          check("post_rst_done", 32'(done), 32'd0);
          check("post_rst_busy", 32'(busy), 32'd0);
        end
        $display("blit pos=(%0d,%0d) flip=%0d aborted by reset at cycle %0d", px, py, fl, k);
        return;
      end
      if (chain && k == N + 3) begin
        start = 1'b1; pos_x = 11'(cpx); pos_y = 11'(cpy); flip_x = cfl;
      end
    end
    check("write_count", 32'(got_writes), 32'(exp_writes));
    if (want_writes >= 0) check("write_count_abs", 32'(got_writes), 32'(want_writes));
    $display("blit pos=(%0d,%0d) flip=%0d writes=%0d expected=%0d", px, py, fl, got_writes, exp_writes);
  endtask

  initial begin
    int rpx, rpy, cpx, cpy;
    bit rfl, cfl;
    for (int i = 0; i < N; i++) rom_mem[i] = 3'd0;
    Reset = 1'b1;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_we", 32'(fb_we), 32'd0);
    check("reset_rom", 32'(rom_address), 32'd0);
    check("reset_fbaddr", 32'(fb_addr), 32'd0);
    check("reset_fbdata", 32'(fb_data), 32'd0);
    Reset = 1'b0;

    // Fully opaque sprite at origin
    fill_rom(1, 1);
    blit(0, 0, 1'b0, 1'b0, -1, -1, 1'b0, 0, 0, 1'b0, 3200);

    // Transparent first pixel
    fill_rom(5, 5);
    rom_mem[0] = 3'd0;
    blit(0, 0, 1'b0, 1'b0, -1, -1, 1'b0, 0, 0, 1'b0, 3199);

    // Mirrored, random content with transparency
    fill_rom(0, 7);
    rom_mem[0] = 3'd3;
    blit(10, 0, 1'b1, 1'b0, -1, -1, 1'b0, 0, 0, 1'b0, -1);

    // Clipped off the left and bottom edges
    fill_rom(1, 7);
    blit(-20, 230, 1'b0, 1'b0, -1, -1, 1'b0, 0, 0, 1'b0, 300);

    // Random placement, start poked while busy, next blit chained in done cycle
    fill_rom(0, 7);
    rpx = int'($urandom_range(420, 0)) - 60;
    rpy = int'($urandom_range(300, 0)) - 60;
    rfl = 1'($urandom);
    cpx = int'($urandom_range(420, 0)) - 60;
    cpy = int'($urandom_range(300, 0)) - 60;
    cfl = 1'($urandom);
    blit(rpx, rpy, rfl, 1'b0, 100, -1, 1'b1, cpx, cpy, cfl, -1);
    blit(cpx, cpy, cfl, 1'b1, -1, -1, 1'b0, 0, 0, 1'b0, -1);

    // Reset in mid-blit, then a clean repeat of the first blit
    fill_rom(1, 1);
    blit(0, 0, 1'b0, 1'b0, -1, 500, 1'b0, 0, 0, 1'b0, -1);
    blit(0, 0, 1'b0, 1'b0, -1, -1, 1'b0, 0, 0, 1'b0, 3200);

    // Mirrored, clipped on the right and bottom
    fill_rom(0, 7);
    blit(300, 200, 1'b1, 1'b0, -1, -1, 1'b0, 0, 0, 1'b0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
